// File: rtl/fifo_producer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_producer_intf : write-side handshake of a synchronous FIFO  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface sync_fifo_producer_intf #(
  parameter int WIDTH = 16
);
  logic             full;
  logic             w_en;
  logic [WIDTH-1:0] data_in;

  modport to_producer (input full, output w_en, output data_in);
  modport to_fifo     (output full, input w_en, input data_in);
endinterface
`default_nettype wire

// File: rtl/fifo_producer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_producer : streams a block of source memory into a FIFO          |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module fifo_producer #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enb,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  input  logic [WIDTH-1:0]  mem_rdata,
  sync_fifo_producer_intf.to_producer producer
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W:0]   pushed_q, pushed_d;
  logic              rd_pend_q, rd_pend_d;
  logic              hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0]  hold_data_q, hold_data_d;

  logic in_fetch;
  logic issue;
  logic avail;
  logic push;
  logic last_push;

  always_comb begin
    in_fetch  = (state_q == S_FETCH);
    issue     = in_fetch & enb & ~producer.full & ~hold_valid_q & (issued_q < len_q);
    avail     = hold_valid_q | rd_pend_q;
    push      = in_fetch & avail & enb & ~producer.full;
    last_push = push & ((pushed_q + CNT_ONE) == len_q);
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign stall    = busy & producer.full;
  assign mem_ren  = issue;
  assign mem_addr = base_q + issued_q[ADDR_W-1:0];

  // Idle data lines are forced low so the bus reads 0 whenever nothing is pending.
  assign producer.w_en    = push;
  assign producer.data_in = hold_valid_q ? hold_data_q :
                            (rd_pend_q ? mem_rdata : '0);

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    len_d        = len_q;
    issued_d     = issued_q;
    pushed_d     = pushed_q;
    rd_pend_d    = issue;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d       = base_addr;
          len_d        = length;
          issued_d     = '0;
          pushed_d     = '0;
          hold_valid_d = 1'b0;
          state_d      = (length == '0) ? S_DONE : S_FETCH;
        end
      end

      S_FETCH: begin
        if (issue) begin
          issued_d = issued_q + CNT_ONE;
        end
        if (push) begin
          pushed_d = pushed_q + CNT_ONE;
        end
        // A returning word that cannot be written is parked; reads stop until it drains.
        if (rd_pend_q && !push) begin
          hold_data_d  = mem_rdata;
          hold_valid_d = 1'b1;
        end else if (hold_valid_q && push) begin
          hold_valid_d = 1'b0;
        end
        if (last_push) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      len_q        <= '0;
      issued_q     <= '0;
      pushed_q     <= '0;
      rd_pend_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      len_q        <= len_d;
      issued_q     <= issued_d;
      pushed_q     <= pushed_d;
      rd_pend_q    <= rd_pend_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_producer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_producer : scoreboard bench for fifo_producer                 |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_fifo_producer;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic              enb;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic              stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ren;
  logic [WIDTH-1:0]  mem_rdata;

  sync_fifo_producer_intf #(.WIDTH(WIDTH)) pif ();

  fifo_producer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enb       (enb),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_ren   (mem_ren),
    .mem_rdata (mem_rdata),
    .producer  (pif)
  );

  logic [WIDTH-1:0]  mem [256];
  int                checks = 0;
  int                errors = 0;
  logic              prev_ren = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  typedef struct {
    logic [7:0] base;
    logic [8:0] len;
    int         fmode;
    int         emode;
    int         poke;
    int         exp_done;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic full_at(input int mode, input int cyc);
    case (mode)
      2:       return (cyc >= 2) && (cyc <= 4);
      3:       return ($urandom_range(0, 2) == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic enb_at(input int mode, input int cyc);
    case (mode)
      1:       return (cyc % 2) == 0;
      2:       return ($urandom_range(0, 3) != 0);
      default: return 1'b1;
    endcase
  endfunction

  // Memory answers one cycle after a strobe; otherwise the read bus carries junk.
  task automatic tick(input logic f, input logic e, input logic s);
    @(posedge clk);
    #1;
    mem_rdata = prev_ren ? mem[prev_addr] : WIDTH'($urandom);
    pif.full  = f;
    enb       = e;
    start     = s;
    #1;
    prev_ren  = mem_ren;
    prev_addr = mem_addr;
  endtask

  task automatic run_xfer(input logic [7:0] base, input logic [8:0] len, input int fmode,
                          input int emode, input int poke, input int exp_done);
    logic [WIDTH-1:0] exp_data [$];
    logic [7:0]       exp_addr [$];
    int done_cnt  = 0;
    int done_cyc  = -1;
    int idle_cyc  = -1;
    int first_ren = -1;
    int first_wen = -1;
    logic s;
    for (int i = 0; i < int'(len); i++) begin
      exp_addr.push_back(8'(int'(base) + i));
      exp_data.push_back(mem[8'(int'(base) + i)]);
    end
    base_addr = base;
    length    = len;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      s = (cyc == 0) || (cyc == poke);
      if (cyc == poke) begin
        base_addr = base ^ 8'h55;
        length    = 9'd3;
      end
      tick(full_at(fmode, cyc), enb_at(emode, cyc), s);
      if (!pif.full) chk("stall_idle", {31'd0, stall}, 32'd0);
      else if (cyc >= 1 && exp_data.size() > 0) chk("stall_full", {31'd0, stall}, 32'd1);
      if (mem_ren) begin
        if (first_ren < 0) first_ren = cyc;
        if (exp_addr.size() == 0) chk("extra_read", 32'd1, 32'd0);
        else chk("rd_addr", {24'd0, mem_addr}, {24'd0, exp_addr.pop_front()});
      end
      if (pif.w_en) begin
        if (first_wen < 0) first_wen = cyc;
        chk("wen_legal", {30'd0, pif.full, enb}, 32'd1);
        if (exp_data.size() == 0) chk("extra_write", 32'd1, 32'd0);
        else chk("wdata", {16'd0, pif.data_in}, {16'd0, exp_data.pop_front()});
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc > done_cyc && !busy) begin
        idle_cyc = cyc;
        break;
      end
    end
    chk("terminated", {31'd0, idle_cyc >= 0}, 32'd1);
    chk("words_left", exp_data.size(), 32'd0);
    chk("reads_left", exp_addr.size(), 32'd0);
    chk("done_count", done_cnt, 32'd1);
    if (exp_done >= 0) begin
      chk("done_cycle", done_cyc, exp_done);
      chk("busy_fall", idle_cyc, exp_done + 1);
      if (len != 0) begin
        chk("first_ren", first_ren, 32'd1);
        chk("first_wen", first_wen, 32'd2);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   {31'd0, busy},        32'd0);
    chk({tag, "_done"},   {31'd0, done},        32'd0);
    chk({tag, "_stall"},  {31'd0, stall},       32'd0);
    chk({tag, "_ren"},    {31'd0, mem_ren},     32'd0);
    chk({tag, "_wen"},    {31'd0, pif.w_en},    32'd0);
    chk({tag, "_addr"},   {24'd0, mem_addr},    32'd0);
    chk({tag, "_data"},   {16'd0, pif.data_in}, 32'd0);
  endtask

  initial begin
    int wcount;
    for (int i = 0; i < 256; i++) mem[i] = WIDTH'($urandom);

    rstn      = 1'b1;
    enb       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    mem_rdata = 16'hA5A5;
    pif.full  = 1'b1;
    #1 rstn = 1'b0;
    #1 chk_all_zero("por");
    pif.full = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rstn = 1'b1;

    tbl[0] = '{8'h10, 9'd4,   0, 0, -1, 6};
    tbl[1] = '{8'h20, 9'd0,   0, 0, -1, 1};
    tbl[2] = '{8'h30, 9'd6,   2, 0, -1, -1};
    tbl[3] = '{8'hFE, 9'd4,   0, 0, -1, 6};
    tbl[4] = '{8'h40, 9'd5,   0, 1, -1, -1};
    tbl[5] = '{8'h80, 9'd7,   0, 0, 2, 9};
    tbl[6] = '{8'hC0, 9'd256, 0, 0, -1, 258};
    foreach (tbl[k]) run_xfer(tbl[k].base, tbl[k].len, tbl[k].fmode, tbl[k].emode,
                              tbl[k].poke, tbl[k].exp_done);

    // Reset in the middle of an 8-word transfer, then a fresh start.
    base_addr = 8'h50;
    length    = 9'd8;
    wcount    = 0;
    tick(1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 20 && wcount < 2; c++) begin
      tick(1'b0, 1'b1, 1'b0);
      if (pif.w_en) wcount++;
    end
    chk("pre_reset_words", wcount, 32'd2);
    pif.full = 1'b1;
    #2 rstn = 1'b0;
    #1 chk_all_zero("mid_rst");
    pif.full = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rstn = 1'b1;
    prev_ren = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, 1'b1, 1'b0);
      chk("post_rst_busy", {31'd0, busy},    32'd0);
      chk("post_rst_ren",  {31'd0, mem_ren}, 32'd0);
    end
    run_xfer(8'h50, 9'd8, 0, 0, -1, 10);

    for (int n = 0; n < 30; n++) begin
      run_xfer(8'($urandom), (n % 7 == 6) ? 9'($urandom_range(0, 256)) : 9'($urandom_range(0, 20)),
               3, 2, ($urandom_range(0, 1) == 1) ? 3 : -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
